// File: rtl/mem_access_unit.sv
// Load/store unit between a multicycle processing unit and a doubleword-wide data memory.
// Sub-doubleword stores use read-modify-write; misaligned requests are rejected without touching memory.
module mem_access_unit #(
  parameter int RD_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Write,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [63:0] Addr,
  input  logic [63:0] StoreData,
  output logic [63:0] LoadData,
  output logic        Done,
  output logic        Busy,
  output logic        Misaligned,
  output logic [63:0] MemAddr,
  output logic [63:0] MemWrData,
  output logic        MemWr,
  input  logic [63:0] MemRdData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [1:0] RD_LAST = 2'(RD_LAT);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] store_q, store_d;
  logic [63:0] load_q, load_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic        mis_q, mis_d;

  logic        req_misaligned;
  logic [63:0] rd_shifted;
  logic [63:0] load_ext;
  logic [7:0]  be_base;
  logic [7:0]  be;
  logic [63:0] store_shifted;
  logic [63:0] merged;

  always_comb begin
    case (Size)
      2'd0:    req_misaligned = 1'b0;
      2'd1:    req_misaligned = Addr[0];
      2'd2:    req_misaligned = |Addr[1:0];
      default: req_misaligned = |Addr[2:0];
    endcase
  end

  // Little-endian extraction: the addressed byte lands in bit 0 before extension.
  always_comb begin
    rd_shifted = MemRdData >> {addr_q[2:0], 3'b000};
    case (size_q)
      2'd0:    load_ext = unsigned_q ? {56'd0, rd_shifted[7:0]}
                                     : {{56{rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1:    load_ext = unsigned_q ? {48'd0, rd_shifted[15:0]}
                                     : {{48{rd_shifted[15]}}, rd_shifted[15:0]};
      2'd2:    load_ext = unsigned_q ? {32'd0, rd_shifted[31:0]}
                                     : {{32{rd_shifted[31]}}, rd_shifted[31:0]};
      default: load_ext = MemRdData;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    be_base = 8'h01;
      2'd1:    be_base = 8'h03;
      2'd2:    be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
    be            = be_base << addr_q[2:0];
    store_shifted = store_q << {addr_q[2:0], 3'b000};
    merged        = MemRdData;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) merged[8*i +: 8] = store_shifted[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    store_d    = store_q;
    load_d     = load_q;
    wr_data_d  = wr_data_q;
    mis_d      = mis_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          write_d    = Write;
          size_d     = Size;
          unsigned_d = Unsigned;
          addr_d     = Addr;
          store_d    = StoreData;
          mis_d      = req_misaligned;
          cnt_d      = 2'd0;
          if (req_misaligned) begin
            state_d = RESP;
          end else if (Write && (Size == 2'd3)) begin
            wr_data_d = StoreData;
            state_d   = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt_q == RD_LAST) begin
          if (write_q) begin
            wr_data_d = merged;
            state_d   = WR;
          end else begin
            load_d  = load_ext;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      write_q    <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      addr_q     <= 64'd0;
      store_q    <= 64'd0;
      load_q     <= 64'd0;
      wr_data_q  <= 64'd0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      load_q     <= load_d;
      wr_data_q  <= wr_data_d;
      mis_q      <= mis_d;
    end
  end

  assign LoadData   = load_q;
  assign MemAddr    = {addr_q[63:3], 3'b000};
  assign MemWrData  = wr_data_q;
  assign MemWr      = (state_q == WR);
  assign Done       = (state_q == RESP);
  assign Misaligned = (state_q == RESP) && mis_q;
  assign Busy       = (state_q != IDLE);

endmodule
